fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_ctrl_if.sv | 34 +++
 rtl/fetch_buf.sv | 33 +++
 rtl/fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_fetch_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: datapath width, fetch FSM encoding, address helper.
// No logic of its own; used by the fetch controller, its buffer and the interface.
// Not applicable: the package has no handshakes.
package riscv_pkg;

  localparam int XLEN = 32;

  // Fetch FSM states; at most one memory request is outstanding at any time.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    OUT  = 3'd3,
    DROP = 3'd4
  } fetch_state_e;

  // Instruction addresses are word aligned; the low two bits of a target are cleared.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the fetch controller, instruction memory and decode.
// Pure wiring, no latency.
// imem side uses req/ready + rvalid; decode side uses valid/ready.
interface fetch_ctrl_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;

  // Fetch controller side.
  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    output if_valid, if_instr, if_pc,
    input  if_ready
  );

  // Memory / decode side.
  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    input  if_valid, if_instr, if_pc,
    output if_ready
  );

endinterface

// File: rtl/fetch_buf.sv
// Single-entry instruction buffer holding the fetched word, its address and a valid flag.
// Load is visible one cycle after the load strobe; flush clears valid in one cycle.
// No backpressure of its own: the controller decides when to load and when to flush.
module fetch_buf
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // Flush wins over load; contents are kept on flush, only valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller driving an external pc register, imem and decode.
// Request -> response -> decode handoff; one request outstanding, response buffered one entry.
// Stalls on imem_ready low and on if_ready low; redirects mask req/valid in their cycle.
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RST_PC_ADDRESS = 32'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_cur,
  output logic            pc_j,
  output logic [XLEN-1:0] pc_jump,
  fetch_ctrl_if.master    bus,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] if_count
);

  fetch_state_e    state, state_nxt;
  logic            redir;
  logic [XLEN-1:0] target;
  logic            req_c;
  logic            accept;
  logic            buf_load;
  logic            buf_flush;
  logic            buf_valid;
  logic            deliver;
  logic [XLEN-1:0] issue_addr;

  // The pc register owns the reset address; referenced only to keep it on this interface.
  logic unused_rst_pc;
  assign unused_rst_pc = ^RST_PC_ADDRESS;

  // Redirect detection: trap beats branch, target always word aligned.
  always_comb begin
    redir  = trap_valid | redirect_valid;
    target = align_word(trap_valid ? trap_pc : redirect_pc);
  end

  // State register; reset lands in IDLE immediately, even mid-transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and outputs; the pc register advances by default, so "hold" reloads pc_cur.
  always_comb begin
    state_nxt = state;
    pc_j      = 1'b1;
    pc_jump   = pc_cur;
    req_c     = 1'b0;
    accept    = 1'b0;
    buf_load  = 1'b0;
    buf_flush = 1'b0;
    deliver   = 1'b0;
    unique case (state)
      IDLE: begin
        // Redirects are ignored here: pc is still coming out of reset.
        state_nxt = REQ;
      end
      REQ: begin
        if (redir) begin
          pc_jump   = target;
          state_nxt = REQ;
        end else begin
          req_c = 1'b1;
          if (bus.imem_ready) begin
            pc_j      = 1'b0;
            accept    = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (redir) begin
          pc_jump   = target;
          // A response arriving with the redirect is discarded on the spot.
          state_nxt = bus.imem_rvalid ? REQ : DROP;
        end else if (bus.imem_rvalid) begin
          buf_load  = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (redir) begin
          pc_jump   = target;
          buf_flush = 1'b1;
          state_nxt = REQ;
        end else if (bus.if_ready) begin
          deliver   = 1'b1;
          buf_flush = 1'b1;
          state_nxt = REQ;
        end
      end
      DROP: begin
        if (redir) begin
          pc_jump = target;
          // If the stale response lands in the same cycle nothing is left to wait for.
          if (bus.imem_rvalid) state_nxt = REQ;
        end else if (bus.imem_rvalid) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Remember the address of the accepted request; pc_cur has moved on by response time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      issue_addr <= '0;
    else if (accept) issue_addr <= pc_cur;
  end

  // Delivered-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       if_count <= '0;
    else if (deliver) if_count <= if_count + 32'd1;
  end

  fetch_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (buf_load),
    .flush    (buf_flush),
    .instr_in (bus.imem_rdata),
    .pc_in    (issue_addr),
    .valid    (buf_valid),
    .instr    (bus.if_instr),
    .pc       (bus.if_pc)
  );

  assign bus.imem_req  = req_c;
  assign bus.imem_addr = pc_cur;
  assign bus.if_valid  = buf_valid & ~redir;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: pc register and memory modelled beside the DUT.
// Transaction-level scoreboard (expected pc, outstanding request, buffered word).
// Directed scenarios followed by randomized traffic with resets and redirects.
module tb_fetch_ctrl;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc_cur;
  logic        pc_j;
  logic [31:0] pc_jump;
  logic        redirect_valid, trap_valid;
  logic [31:0] redirect_pc, trap_pc;
  logic [31:0] if_count;

  fetch_ctrl_if bus();

  fetch_ctrl #(.RST_PC_ADDRESS(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_cur         (pc_cur),
    .pc_j           (pc_j),
    .pc_jump        (pc_jump),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .if_count       (if_count)
  );

  always #5 clk = ~clk;

  // External pc register: reloads on pc_j, otherwise advances by one word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pc_cur <= RST_PC;
    else if (pc_j) pc_cur <= pc_jump;
    else           pc_cur <= pc_cur + 32'd4;
  end

  int n_chk = 0;
  int n_fail = 0;

  // Scoreboard / environment state.
  logic [31:0] exp_pc, acc_addr, buf_pc, exp_cnt, mem_addr, last_acc_dut;
  logic        have_buf, killed, first, mem_busy;
  logic        did_acc, did_del, did_rv;
  int          mem_cnt, mem_lat, tot_del;
  logic [31:0] del_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // One clock cycle: drive memory response, check outputs, update model, advance.
  task automatic step();
    logic        redir, req_exp, del;
    logic [31:0] tgt;
    bus.imem_rvalid = mem_busy && (mem_cnt == 0);
    bus.imem_rdata  = bus.imem_rvalid ? memfn(mem_addr) : 32'hdead_beef;
    #1;
    redir   = (redirect_valid | trap_valid) & ~first;
    tgt     = (trap_valid ? trap_pc : redirect_pc) & ~32'h3;
    req_exp = ~first & ~mem_busy & ~have_buf & ~redir;
    del     = have_buf & ~redir & bus.if_ready;

    check_eq("pc_cur", pc_cur, exp_pc);
    check_eq("imem_req", {31'b0, bus.imem_req}, {31'b0, req_exp});
    if (req_exp) check_eq("imem_addr", bus.imem_addr, exp_pc);
    check_eq("if_valid", {31'b0, bus.if_valid}, {31'b0, have_buf & ~redir});
    if (have_buf) begin
      check_eq("if_pc", bus.if_pc, buf_pc);
      check_eq("if_instr", bus.if_instr, memfn(buf_pc));
    end
    check_eq("pc_j", {31'b0, pc_j}, {31'b0, ~(req_exp & bus.imem_ready)});
    if (redir) check_eq("pc_jump_redir", pc_jump, tgt);
    else if (!(req_exp & bus.imem_ready)) check_eq("pc_jump_hold", pc_jump, pc_cur);
    check_eq("if_count", if_count, exp_cnt);

    did_acc = req_exp & bus.imem_ready;
    did_del = del;
    did_rv  = bus.imem_rvalid;
    if (redir) begin
      exp_pc   = tgt;
      have_buf = 1'b0;
      killed   = 1'b1;
    end
    if (did_acc) begin
      acc_addr     = exp_pc;
      last_acc_dut = bus.imem_addr;
      exp_pc       = exp_pc + 32'd4;
      killed       = 1'b0;
    end
    if (did_rv && !killed && !redir) begin
      have_buf = 1'b1;
      buf_pc   = acc_addr;
    end
    if (del) begin
      have_buf = 1'b0;
      exp_cnt  = exp_cnt + 32'd1;
      tot_del++;
      del_q.push_back(buf_pc);
    end
    first = 1'b0;

    // Memory: one response per accepted request, mem_lat cycles after accept.
    if (did_rv) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (bus.imem_req && bus.imem_ready) begin
      mem_busy = 1'b1;
      mem_cnt  = mem_lat - 1;
      mem_addr = bus.imem_addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    trap_valid = 1'b0;
    #1;
    check_eq("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
    check_eq("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
    check_eq("rst_pc_j", {31'b0, pc_j}, 32'd1);
    check_eq("rst_pc_jump", pc_jump, pc_cur);
    check_eq("rst_if_count", if_count, 32'd0);
    check_eq("rst_if_pc", bus.if_pc, 32'd0);
    check_eq("rst_if_instr", bus.if_instr, 32'd0);
    mem_busy = 1'b0; have_buf = 1'b0; killed = 1'b0; first = 1'b1;
    exp_pc = RST_PC; exp_cnt = '0; del_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold_if_valid", {31'b0, bus.if_valid}, 32'd0);
    check_eq("rst_hold_pc_cur", pc_cur, RST_PC);
    rst_n = 1'b1;
  endtask

  // what: 0 = request accepted, 1 = instruction delivered, 2 = word buffered for decode.
  task automatic step_until(input int what, input string tag);
    logic hit = 1'b0;
    for (int n = 0; n < 64 && !hit; n++) begin
      step();
      hit = (what == 0) ? did_acc : ((what == 1) ? did_del : have_buf);
    end
    check_eq(tag, {31'b0, hit}, 32'd1);
  endtask

  initial begin
    logic [31:0] s_instr, s_pc, s_pcc, cnt_before;
    logic        rv_seen;
    bus.imem_ready = 1'b0; bus.if_ready = 1'b0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    redirect_valid = 1'b0; trap_valid = 1'b0;
    redirect_pc = '0; trap_pc = '0;
    mem_lat = 1; mem_cnt = 0; mem_addr = '0; tot_del = 0;
    acc_addr = '0; buf_pc = '0; last_acc_dut = '0;
    #2;

    // Back-to-back fetch from reset: 0x0, 0x4, 0x8.
    do_reset();
    bus.imem_ready = 1'b1; bus.if_ready = 1'b1; mem_lat = 1;
    repeat (3) step_until(1, "t1_deliver");
    check_eq("t1_n_del", del_q.size(), 32'd3);
    if (del_q.size() == 3) begin
      check_eq("t1_pc0", del_q[0], 32'h0);
      check_eq("t1_pc1", del_q[1], 32'h4);
      check_eq("t1_pc2", del_q[2], 32'h8);
    end
    check_eq("t1_count", if_count, 32'd3);

    // Memory not ready for three cycles while requesting 0x4.
    do_reset();
    bus.imem_ready = 1'b1; bus.if_ready = 1'b1; mem_lat = 1;
    step_until(1, "t2_deliver");
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_pc_stall", pc_cur, 32'h4);
      check_eq("t2_addr_stall", bus.imem_addr, 32'h4);
      step();
    end
    bus.imem_ready = 1'b1;
    step();
    check_eq("t2_accept", {31'b0, did_acc}, 32'd1);
    check_eq("t2_pc_adv", pc_cur, 32'h8);

    // Redirect while waiting; late response must be dropped.
    do_reset();
    bus.imem_ready = 1'b1; bus.if_ready = 1'b1; mem_lat = 3;
    step_until(0, "t3_accept");
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    rv_seen = 1'b0;
    for (int n = 0; n < 10 && !bus.imem_req; n++) begin
      step();
      rv_seen |= did_rv;
    end
    check_eq("t3_rv_seen", {31'b0, rv_seen}, 32'd1);
    check_eq("t3_req", {31'b0, bus.imem_req}, 32'd1);
    check_eq("t3_addr", bus.imem_addr, 32'h100);
    check_eq("t3_no_deliver", del_q.size(), 32'd0);

    // Trap and redirect together while an instruction waits for decode.
    do_reset();
    bus.imem_ready = 1'b1; bus.if_ready = 1'b0; mem_lat = 1;
    step_until(2, "t4_out");
    cnt_before = if_count;
    trap_valid = 1'b1; trap_pc = 32'h200;
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    trap_valid = 1'b0; redirect_valid = 1'b0;
    check_eq("t4_pc", pc_cur, 32'h200);
    check_eq("t4_if_valid", {31'b0, bus.if_valid}, 32'd0);
    check_eq("t4_count", if_count, cnt_before);

    // Decode stalled for five cycles: output stable, pc held.
    do_reset();
    bus.imem_ready = 1'b1; bus.if_ready = 1'b0; mem_lat = 1;
    step_until(2, "t5_out");
    s_instr = bus.if_instr; s_pc = bus.if_pc; s_pcc = pc_cur;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t5_valid", {31'b0, bus.if_valid}, 32'd1);
      check_eq("t5_instr", bus.if_instr, s_instr);
      check_eq("t5_ifpc", bus.if_pc, s_pc);
      check_eq("t5_pc_hold", pc_cur, s_pcc);
    end
    bus.if_ready = 1'b1;
    step();
    check_eq("t5_count", if_count, 32'd1);

    // Reset during WAIT, then restart from the reset address.
    do_reset();
    bus.imem_ready = 1'b1; bus.if_ready = 1'b1; mem_lat = 1;
    step_until(1, "t6_deliver");
    step_until(1, "t6_deliver");
    mem_lat = 3;
    step_until(0, "t6_accept");
    step();
    do_reset();
    last_acc_dut = 32'hffff_ffff;
    step_until(0, "t6_accept2");
    check_eq("t6_first_fetch", last_acc_dut, RST_PC);

    // Randomized traffic with stalls, redirects, traps and occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.imem_ready = ($urandom_range(0, 9) < 7);
      bus.if_ready   = ($urandom_range(0, 9) < 6);
      mem_lat        = $urandom_range(1, 4);
      redirect_valid = ($urandom_range(0, 99) < 5);
      trap_valid     = ($urandom_range(0, 99) < 3);
      redirect_pc    = $urandom;
      trap_pc        = $urandom;
      if ($urandom_range(0, 999) == 0) do_reset();
      step();
    end
    check_eq("rand_progress", {31'b0, (tot_del > 100)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
